// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : Chunked ripple-carry adder/subtractor. Each stage adds CHUNK
//            bits and passes the carry in a register to the next stage, so
//            the result leaves STAGES = WIDTH/CHUNK cycles after acceptance.
//            The handshake is valid/ready on both sides. The whole pipe
//            advances together and stalls only while the output is held.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            in_valid/in_ready     - operand beat handshake
//            a, b [WIDTH]          - operands
//            cin                   - carry-in (ignored when sub=1)
//            sub                   - 0: a+b+cin, 1: a-b
//            out_valid/out_ready   - result beat handshake
//            sum [WIDTH]           - result
//            cout                  - carry out of MSB (borrow-not for sub)
//            ovf                   - signed two's-complement overflow
// Config   : `define PIPELINED_ADDER_SAT_EN to clamp sum to the signed
//            max/min on overflow; otherwise sum wraps.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_stages = WIDTH / CHUNK;
    localparam int c_last   = c_stages - 1;

`ifdef PIPELINED_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Stage registers. Each stage holds the operands (B already inverted
    // for subtraction), the partial sum so far, and the carry out of its
    // chunk.
    logic [WIDTH-1:0] r_a [c_stages];
    logic [WIDTH-1:0] r_b [c_stages];
    logic [WIDTH-1:0] r_s [c_stages];
    logic             r_c [c_stages];
    logic             r_v [c_stages];
    logic             r_ovf;

    // Stage inputs (w_a/w_b/w_s/w_c/w_v) and stage results.
    logic [WIDTH-1:0] w_a   [c_stages];
    logic [WIDTH-1:0] w_b   [c_stages];
    logic [WIDTH-1:0] w_s   [c_stages];
    logic [WIDTH-1:0] w_sn  [c_stages];
    logic             w_c   [c_stages];
    logic             w_v   [c_stages];
    logic             w_co  [c_stages];
    logic [CHUNK:0]   w_add [c_stages];

    logic             w_adv;
    logic             w_msb_cin;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    assign w_adv    = !r_v[c_last] || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        // Subtraction is a + ~b + 1, so the inversion and forced carry are
        // applied once on entry and then travel with the beat.
        w_a[0] = a;
        w_b[0] = sub ? ~b : b;
        w_c[0] = sub | cin;
        w_s[0] = '0;
        w_v[0] = in_valid;
        for (int k = 1; k < c_stages; k++) begin
            w_a[k] = r_a[k-1];
            w_b[k] = r_b[k-1];
            w_c[k] = r_c[k-1];
            w_s[k] = r_s[k-1];
            w_v[k] = r_v[k-1];
        end
        for (int k = 0; k < c_stages; k++) begin
            w_add[k] = {1'b0, w_a[k][k*CHUNK +: CHUNK]}
                     + {1'b0, w_b[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, w_c[k]};
            w_co[k]  = w_add[k][CHUNK];
            w_sn[k]  = w_s[k];
            w_sn[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit. Overflow is
    // the disagreement between the carry into the MSB and the carry out of it.
    always_comb begin
        w_msb_cin = w_a[c_last][WIDTH-1] ^ w_b[c_last][WIDTH-1] ^ w_sn[c_last][WIDTH-1];
        w_ovf     = w_co[c_last] ^ w_msb_cin;
        w_res     = w_sn[c_last];
`ifdef PIPELINED_ADDER_SAT_EN
        // On overflow the wrapped sign is wrong. A negative-looking result
        // means the true value was positive.
        if (w_ovf) begin
            w_res = w_sn[c_last][WIDTH-1] ? c_smax : c_smin;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < c_stages; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < c_stages; k++) begin
                r_a[k] <= w_a[k];
                r_b[k] <= w_b[k];
                r_c[k] <= w_co[k];
                r_v[k] <= w_v[k];
            end
            for (int k = 0; k < c_last; k++) begin
                r_s[k] <= w_sn[k];
            end
            r_s[c_last] <= w_res;
            r_ovf       <= w_ovf;
        end
    end

    assign out_valid = r_v[c_last];
    assign sum       = r_s[c_last];
    assign cout      = r_c[c_last];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
